morse_char_sequencer: RTL

MORSE_CHAR_SEQUENCER -- requirements
Module: morse_char_sequencer

---
 rtl/morse_char_sequencer_pkg.sv | 24 ++
 rtl/morse_char_sequencer_char_fifo.sv | 54 +++++
 rtl/morse_char_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/morse_char_sequencer_pkg.sv
// Shared types and constants for the Morse character sequencer.
// A record is {len[2:0], code[4:0]}; a length of zero marks a word space.
package morse_char_sequencer_pkg;

  localparam int REC_W   = 8;
  localparam int MAX_SYM = 5;
  localparam int CODE_W  = 5;
  localparam int LEN_W   = 3;

  localparam logic [LEN_W-1:0] SPACE_LEN = '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_OVERRUN,
    ST_EMIT_SPACE
  } state_t;

  function automatic logic [REC_W-1:0] make_rec(input logic [LEN_W-1:0]  len,
                                                input logic [CODE_W-1:0] code);
    return {len, code};
  endfunction

endpackage

// File: rtl/morse_char_sequencer_char_fifo.sv
// First-word-fall-through record FIFO; a push while full is accepted only
// when a pop frees the head slot in the same cycle.
module char_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;
  logic             w_push_ok;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign w_pop     = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop);
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/morse_char_sequencer.sv
// Assembles dot/dash pulses into character records and queues them,
// inserting a single space record per word gap.
module morse_char_sequencer #(
  parameter int DEPTH   = 4,
  parameter int MAX_SYM = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dot,
  input  logic       dash,
  input  logic       lg,
  input  logic       wg,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic [2:0] sym_count,
  output logic       overflow,
  output logic       sym_err
);
  import morse_char_sequencer_pkg::*;

  state_t            r_state;
  state_t            w_app_state;
  state_t            w_state_nxt;
  logic [LEN_W-1:0]  r_cnt;
  logic [LEN_W-1:0]  w_app_cnt;
  logic [LEN_W-1:0]  w_cnt_nxt;
  logic [CODE_W-1:0] r_code;
  logic [CODE_W-1:0] w_app_code;
  logic [CODE_W-1:0] w_code_nxt;
  logic              r_last_space;
  logic              r_overflow;
  logic              r_sym_err;
  logic              w_sym;
  logic              w_both;
  logic              w_err;
  logic              w_push;
  logic [REC_W-1:0]  w_push_data;
  logic              w_full;
  logic              w_empty;
  logic              w_drop;

  // Symbol is applied first, then any gap closes the character including it.
  always_comb begin
    w_sym       = dot ^ dash;
    w_both      = dot & dash;
    w_err       = w_both;
    w_app_state = r_state;
    w_app_cnt   = r_cnt;
    w_app_code  = r_code;
    w_push      = 1'b0;
    w_push_data = '0;

    case (r_state)
      ST_IDLE, ST_EMIT_SPACE: begin
        if (w_sym) begin
          w_app_state = ST_COLLECT;
          w_app_cnt   = LEN_W'(1);
          w_app_code  = {{(CODE_W-1){1'b0}}, dash};
        end else if (r_state == ST_EMIT_SPACE) begin
          w_app_state = ST_IDLE;
          w_app_cnt   = '0;
          w_app_code  = '0;
        end
      end
      ST_COLLECT: begin
        if (w_sym) begin
          if (r_cnt == LEN_W'(MAX_SYM)) begin
            w_app_state = ST_OVERRUN;
            w_err       = 1'b1;
          end else begin
            w_app_cnt  = r_cnt + 1'b1;
            w_app_code = {r_code[CODE_W-2:0], dash};
          end
        end
      end
      default: ;
    endcase

    w_state_nxt = w_app_state;
    w_cnt_nxt   = w_app_cnt;
    w_code_nxt  = w_app_code;

    if (r_state == ST_EMIT_SPACE) begin
      w_push      = 1'b1;
      w_push_data = make_rec(SPACE_LEN, '0);
    end else if (!w_both && (lg || wg)) begin
      case (w_app_state)
        ST_COLLECT, ST_OVERRUN: begin
          w_push      = (w_app_state == ST_COLLECT);
          w_push_data = make_rec(w_app_cnt, w_app_code);
          w_state_nxt = wg ? ST_EMIT_SPACE : ST_IDLE;
          w_cnt_nxt   = '0;
          w_code_nxt  = '0;
        end
        default: begin
          if (wg && !r_last_space) begin
            w_push      = 1'b1;
            w_push_data = make_rec(SPACE_LEN, '0);
          end
        end
      endcase
    end
  end

  assign w_drop = w_push && w_full && !(rd_en && !w_empty);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_code       <= '0;
      r_last_space <= 1'b1;
      r_overflow   <= 1'b0;
      r_sym_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_code  <= w_code_nxt;
      if (w_err) r_sym_err <= 1'b1;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (w_push) begin
        r_last_space <= (w_push_data[REC_W-1 -: LEN_W] == SPACE_LEN);
      end
    end
  end

  char_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (rd_en),
    .o_rd_data   (rd_data),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  assign rd_valid  = !w_empty;
  assign sym_count = r_cnt;
  assign overflow  = r_overflow;
  assign sym_err   = r_sym_err;

endmodule
